demux4_buf: RTL and testbench

- 1-to-4 registered demultiplexer with valid/ready handshakes; the inverse of the datapath's 4:1 select path.
- Routes one WIDTH-bit producer stream to one of four consumer channels chosen per-word by in_sel.
- Each channel has its own 2-entry buffer, so a stalled consumer never blocks traffic to the other channels.
- Sits between the CPU store/IO path and up to four memory-mapped peripherals.

---
 rtl/demux_pkg.sv | 15 +
 rtl/chan_buf2.sv | 68 ++++++
 rtl/demux4_buf.sv | 83 ++++++++
 tb/tb_demux4_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 4-way registered demultiplexer and its channel buffers.
// The optional per-channel pop counters are enabled with the DEMUX4_STATS_EN macro.
package demux_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_DEPTH = 2;
  localparam int SEL_W    = 2;
  localparam int STAT_W   = 16;

  // Channel buffer occupancy doubles as the per-channel state.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/chan_buf2.sv
// Two-entry per-channel FIFO: head register drives the consumer, tail holds the
// second word. Occupancy (o_count) is the state and is exported for observation.
module chan_buf2
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count,
  output logic             o_valid,
  output logic             o_not_full
);

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != ST_TWO);
  assign w_pop  = i_pop && (r_count != ST_EMPTY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        ST_EMPTY: begin
          if (w_push) begin
            r_head  <= i_din;
            r_count <= ST_ONE;
          end
        end
        ST_ONE: begin
          // Push and pop together: the old head leaves, the new word takes its place.
          if (w_push && w_pop) begin
            r_head <= i_din;
          end else if (w_push) begin
            r_tail  <= i_din;
            r_count <= ST_TWO;
          end else if (w_pop) begin
            r_count <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= ST_ONE;
          end
        end
        default: r_count <= ST_EMPTY;
      endcase
    end
  end

  assign o_head     = r_head;
  assign o_count    = r_count;
  assign o_valid    = (r_count != ST_EMPTY);
  assign o_not_full = (r_count != ST_TWO);

endmodule

// File: rtl/demux4_buf.sv
// 1-to-4 registered demultiplexer with a 2-entry buffer per channel.
// Define DEMUX4_STATS_EN to add per-channel pop counters readable via stat_sel/stat_cnt.
module demux4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data0,
  output logic [WIDTH-1:0]  out_data1,
  output logic [WIDTH-1:0]  out_data2,
  output logic [WIDTH-1:0]  out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready
`ifdef DEMUX4_STATS_EN
  ,
  input  logic [SEL_W-1:0]  stat_sel,
  output logic [STAT_W-1:0] stat_cnt
`endif
);

  // Handshake: a word moves on any edge where valid && ready are both high;
  // in_ready depends only on in_sel and registered occupancy, never on out_ready.
  logic [WIDTH-1:0]  w_head [NUM_CH];
  logic [1:0]        w_count [NUM_CH];
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_not_full;
  logic              w_accept;

  assign in_ready = reset_n && w_not_full[in_sel];
  assign w_accept = in_valid && in_ready;
  assign w_pop    = w_valid & out_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_push[k] = w_accept && (in_sel == SEL_W'(k));

    chan_buf2 #(.WIDTH(WIDTH)) u_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_push     (w_push[k]),
      .i_pop      (w_pop[k]),
      .i_din      (in_data),
      .o_head     (w_head[k]),
      .o_count    (w_count[k]),
      .o_valid    (w_valid[k]),
      .o_not_full (w_not_full[k])
    );

    a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
      w_count[k] <= ST_TWO);
  end

  assign out_valid = w_valid;
  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

`ifdef DEMUX4_STATS_EN
  logic [STAT_W-1:0] r_stat [NUM_CH];

  // Counters wrap naturally at 2^STAT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) r_stat[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_pop[k]) r_stat[k] <= r_stat[k] + STAT_W'(1);
      end
    end
  end

  assign stat_cnt = r_stat[stat_sel];
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: per-channel queue model, directed scenarios
// with literal expectations, then randomized traffic. Stats checks need DEMUX4_STATS_EN.
module tb_demux4_buf;

  localparam int W = 16;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef DEMUX4_STATS_EN
  logic [1:0]   stat_sel;
  logic [15:0]  stat_cnt;
`endif

  demux4_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX4_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[4][$];
  logic [W-1:0] last_data[4];
  int           pop_cnt[4];
  logic         acc_flag;
  logic         cmp_en;
  int           tests_run;
  int           fails;
  logic [W-1:0] dut_data[4];

  assign dut_data[0] = out_data0;
  assign dut_data[1] = out_data1;
  assign dut_data[2] = out_data2;
  assign dut_data[3] = out_data3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
      pop_cnt[k]   = 0;
    end
    acc_flag = 1'b0;
  endtask

  // Model: at each rising edge, consumers take heads, then the offered word joins its queue
  // if that queue held fewer than two words before the edge.
  always @(posedge clk) begin
    if (reset_n) begin
      acc_flag = in_valid && (exp_q[in_sel].size() < 2);
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() > 0 && out_ready[k]) begin
          void'(exp_q[k].pop_front());
          pop_cnt[k]++;
        end
      end
      if (acc_flag) exp_q[in_sel].push_back(in_data);
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() > 0) last_data[k] = exp_q[k][0];
      end
    end
  end

  // Compare process: mid-cycle, outputs must match the model.
  always @(negedge clk) begin
    #3;
    if (cmp_en) begin
      if (!reset_n) check("cmp_in_ready_rst", {31'd0, in_ready}, 32'd0);
      else check("cmp_in_ready", {31'd0, in_ready}, {31'd0, exp_q[in_sel].size() < 2});
      for (int k = 0; k < 4; k++) begin
        check($sformatf("cmp_valid%0d", k), {31'd0, out_valid[k]}, {31'd0, exp_q[k].size() > 0});
        check($sformatf("cmp_data%0d", k), {16'd0, dut_data[k]}, {16'd0, last_data[k]});
      end
`ifdef DEMUX4_STATS_EN
      check("cmp_stat", {16'd0, stat_cnt}, pop_cnt[stat_sel] & 32'hFFFF);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    cmp_en    = 1'b0;
    model_clear();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    in_sel    = 2'd0;
    out_ready = 4'hF;
`ifdef DEMUX4_STATS_EN
    stat_sel  = 2'd0;
`endif
    cmp_en    = 1'b1;

    // Reset with an offer pending
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_data%0d", k), {16'd0, dut_data[k]}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Routing, one word per channel, consumers always ready
    tick();
    check("route0_valid", {28'd0, out_valid}, 32'h1);
    check("route0_data", {16'd0, out_data0}, 32'h1111);
    in_data = 16'h2222; in_sel = 2'd1;
    tick();
    check("route1_valid", {28'd0, out_valid}, 32'h2);
    check("route1_data", {16'd0, out_data1}, 32'h2222);
    in_data = 16'h3333; in_sel = 2'd2;
    tick();
    check("route2_valid", {28'd0, out_valid}, 32'h4);
    check("route2_data", {16'd0, out_data2}, 32'h3333);
    in_data = 16'h4444; in_sel = 2'd3;
    tick();
    check("route3_valid", {28'd0, out_valid}, 32'h8);
    check("route3_data", {16'd0, out_data3}, 32'h4444);
    in_valid = 1'b0;
    tick();
    check("route_drained", {28'd0, out_valid}, 32'h0);

    // Full channel and backpressure
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hA001;
    tick();
    in_data = 16'hA002;
    tick();
    check("full_valid2", {31'd0, out_valid[2]}, 32'd1);
    check("full_head", {16'd0, out_data2}, 32'hA001);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("full_hold_ready", {31'd0, in_ready}, 32'd0);
    check("full_hold_head", {16'd0, out_data2}, 32'hA001);
    in_sel = 2'd0; in_data = 16'hA003;
    #1;
    check("other_ch_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("other_ch_valid", {28'd0, out_valid}, 32'h5);
    check("other_ch_data", {16'd0, out_data0}, 32'hA003);
    in_valid = 1'b0; out_ready = 4'b0100;
    tick();
    check("pop2_head", {16'd0, out_data2}, 32'hA002);
    check("pop2_valid", {28'd0, out_valid}, 32'h5);
    out_ready = 4'h0; in_sel = 2'd2;
    #1;
    check("pop2_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 4'hF;
    tick();
    tick();
    check("full_drained", {28'd0, out_valid}, 32'h0);

    // Simultaneous push and pop on one channel
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 16'hBEEF;
    tick();
    check("pp_first", {16'd0, out_data1}, 32'hBEEF);
    in_data = 16'hCAFE; out_ready = 4'b0010;
    tick();
    check("pp_head", {16'd0, out_data1}, 32'hCAFE);
    check("pp_valid", {28'd0, out_valid}, 32'h2);
    in_valid = 1'b0; out_ready = 4'h0;
    #1;
    check("pp_count_one", {31'd0, in_ready}, 32'd1);
    out_ready = 4'b0010;
    tick();
    check("pp_empty", {28'd0, out_valid}, 32'h0);

    // Asynchronous reset with channel 3 full
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 16'hD001;
    tick();
    in_data = 16'hD002;
    tick();
    in_valid = 1'b0;
    check("mid_full_valid", {28'd0, out_valid}, 32'h8);
    check("mid_full_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    check("mid_rst_valid", {28'd0, out_valid}, 32'h0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_data3", {16'd0, out_data3}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", {28'd0, out_valid}, 32'h0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Randomized traffic; the producer holds its offer until accepted
    for (int i = 0; i < 2000; i++) begin
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
        in_sel   = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
`ifdef DEMUX4_STATS_EN
      stat_sel = 2'($urandom_range(0, 3));
`endif
      tick();
    end

`ifdef DEMUX4_STATS_EN
    // Counter wrap: 70000 pops on channel 0 after a fresh reset
    in_valid = 1'b0; out_ready = 4'hF;
    tick();
    reset_n = 1'b0;
    model_clear();
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001;
    for (int i = 0; i < 70000; i++) begin
      in_data = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    stat_sel = 2'd0;
    #1;
    check("stat_ch0_wrap", {16'd0, stat_cnt}, 32'd4464);
    for (int k = 1; k < 4; k++) begin
      stat_sel = 2'(k);
      #1;
      check($sformatf("stat_ch%0d_zero", k), {16'd0, stat_cnt}, 32'd0);
    end
`endif

    in_valid = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
